// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: funct3 codes, FSM states and byte-lane helpers shared by the LSU.
package load_store_unit_pkg;
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, LOAD_DATA} lsu_state_t;

    // Unknown size codes (including unsigned sizes on stores) take the trap path.
    function automatic logic access_ok(input logic store, input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            LSU_B:   return 1'b1;
            LSU_H:   return !a[0];
            LSU_W:   return a == 2'b00;
            LSU_BU:  return !store;
            LSU_HU:  return !store && !a[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        return f3 == LSU_B ? {4{d[7:0]}} : f3 == LSU_H ? {2{d[15:0]}} : d;
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
        return f3 == LSU_B ? 4'b0001 << a : f3 == LSU_H ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
endpackage

// File: rtl/load_store_unit_load_align.sv
// load_align: selects the addressed byte/half of a read word and sign/zero-extends it.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [31:0] sh;

    assign sh = rdata >> {addr, 3'b000};

    always_comb begin
        case (funct3)
            LSU_B:   result = {{24{sh[7]}}, sh[7:0]};
            LSU_H:   result = {{16{sh[15]}}, sh[15:0]};
            LSU_BU:  result = {24'b0, sh[7:0]};
            LSU_HU:  result = {16'b0, sh[15:0]};
            default: result = sh;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage driving a byte-masked synchronous RAM and producing
// a registered writeback packet; stalls while a memory access is outstanding.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic                  is_load,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [WORD_SIZE-1:0]  alu_out,
    input  logic [WORD_SIZE-1:0]  store_data,
    input  logic [4:0]            rd_in,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    output logic [3:0]            mem_wmask,
    input  logic                  mem_ready,
    input  logic [WORD_SIZE-1:0]  mem_rdata,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [4:0]            wb_rd,
    output logic [WORD_SIZE-1:0]  wb_data,
    output logic                  misaligned
);
    lsu_state_t            state_q, state_d;
    logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]  mem_wdata_q, mem_wdata_d, wb_data_q, wb_data_d;
    logic [3:0]            mem_wmask_q, mem_wmask_d;
    logic                  wb_valid_q, wb_valid_d, wb_we_q, wb_we_d, misaligned_q, misaligned_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            lo_q, lo_d;
    logic [31:0]           load_result;

    load_align u_align (
        .rdata  (mem_rdata),
        .addr   (lo_q),
        .funct3 (f3_q),
        .result (load_result)
    );

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = 1'b0;
        misaligned_d = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        f3_d         = f3_q;
        lo_d         = lo_q;
        case (state_q)
            IDLE: if (valid_in) begin
                wb_rd_d = rd_in;
                if (!is_load && !is_store) begin
                    wb_valid_d = 1'b1;
                    wb_we_d    = rd_in != 5'd0;
                    wb_data_d  = alu_out;
                end else if (!access_ok(is_store, funct3, alu_out[1:0])) begin
                    wb_valid_d   = 1'b1;
                    misaligned_d = 1'b1;
                end else begin
                    state_d     = ACCESS;
                    mem_req_d   = 1'b1;
                    mem_we_d    = is_store;
                    mem_addr_d  = {alu_out[ADDR_WIDTH-1:2], 2'b00};
                    mem_wdata_d = store_lanes(funct3, store_data);
                    mem_wmask_d = store_mask(funct3, alu_out[1:0]);
                    f3_d        = funct3;
                    lo_d        = alu_out[1:0];
                end
            end
            ACCESS: if (mem_ready) begin
                mem_req_d  = 1'b0;
                mem_we_d   = 1'b0;
                state_d    = mem_we_q ? IDLE : LOAD_DATA;
                wb_valid_d = mem_we_q;
            end
            LOAD_DATA: begin
                state_d    = IDLE;
                wb_valid_d = 1'b1;
                wb_we_d    = wb_rd_q != 5'd0;
                wb_data_d  = load_result;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= 4'b0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            misaligned_q <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= '0;
            f3_q         <= 3'd0;
            lo_q         <= 2'd0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            misaligned_q <= misaligned_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            f3_q         <= f3_d;
            lo_q         <= lo_d;
        end
    end

    assign ready_in   = state_q == IDLE;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wmask  = mem_wmask_q;
    assign wb_valid   = wb_valid_q;
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign misaligned = misaligned_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench; inputs change and outputs are checked on the falling edge.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset, valid_in, ready_in, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] alu_out, store_data, mem_addr, mem_wdata, mem_rdata, wb_data;
    logic [4:0]  rd_in, wb_rd;
    logic        mem_req, mem_we, mem_ready, wb_valid, wb_we, misaligned;
    logic [3:0]  mem_wmask;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .is_load(is_load), .is_store(is_store), .funct3(funct3), .alu_out(alu_out),
        .store_data(store_data), .rd_in(rd_in), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_we(wb_we),
        .wb_rd(wb_rd), .wb_data(wb_data), .misaligned(misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        valid_in = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        alu_out = a; store_data = d; rd_in = rd;
        tick();
        valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [31:0] exp);
        mem_ready = 1'b1;
        issue(1'b1, 1'b0, f3, a, 32'd0, 5'd3);
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
        tick();
        mem_rdata = rdata;
        chk({tag, "_req_drop"}, {31'd0, mem_req}, 32'd0);
        tick();
        chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
        chk({tag, "_wbwe"}, {31'd0, wb_we}, 32'd1);
        chk({tag, "_data"}, wb_data, exp);
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        alu_out = 32'd0; store_data = 32'd0; rd_in = 5'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_ready", {31'd0, ready_in}, 32'd1);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
        chk("rst_wmask", {28'd0, mem_wmask}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);

        issue(1'b0, 1'b0, 3'd0, 32'd20, 32'd0, 5'd5);
        chk("pt_wbv", {31'd0, wb_valid}, 32'd1);
        chk("pt_wbwe", {31'd0, wb_we}, 32'd1);
        chk("pt_data", wb_data, 32'd20);
        chk("pt_rd", {27'd0, wb_rd}, 32'd5);
        issue(1'b0, 1'b0, 3'd0, 32'd7, 32'd0, 5'd0);
        chk("pt_rd0_wbv", {31'd0, wb_valid}, 32'd1);
        chk("pt_rd0_wbwe", {31'd0, wb_we}, 32'd0);
        tick();
        chk("pt_pulse", {31'd0, wb_valid}, 32'd0);

        mem_ready = 1'b1;
        issue(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 5'd0);
        chk("sb_req", {31'd0, mem_req}, 32'd1);
        chk("sb_we", {31'd0, mem_we}, 32'd1);
        chk("sb_addr", mem_addr, 32'h100);
        chk("sb_wmask", {28'd0, mem_wmask}, 32'b1000);
        chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("sb_stall", {31'd0, ready_in}, 32'd0);
        tick();
        chk("sb_wbv", {31'd0, wb_valid}, 32'd1);
        chk("sb_wbwe", {31'd0, wb_we}, 32'd0);
        chk("sb_ready", {31'd0, ready_in}, 32'd1);
        issue(1'b0, 1'b1, 3'b001, 32'h10A, 32'h1234BEEF, 5'd0);
        chk("sh_wmask", {28'd0, mem_wmask}, 32'b1100);
        chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
        tick();
        issue(1'b0, 1'b1, 3'b010, 32'h20C, 32'hCAFEF00D, 5'd0);
        chk("sw_wmask", {28'd0, mem_wmask}, 32'b1111);
        chk("sw_wdata", mem_wdata, 32'hCAFEF00D);
        tick();

        do_load("lb", 3'b000, 32'h101, 32'h0000F000, 32'hFFFFFFF0);
        do_load("lbu", 3'b100, 32'h101, 32'h0000F000, 32'h000000F0);
        do_load("lh", 3'b001, 32'h102, 32'h80000000, 32'hFFFF8000);
        do_load("lhu", 3'b101, 32'h102, 32'h80000000, 32'h00008000);

        mem_ready = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 5'd9);
        for (int i = 1; i <= 3; i++) begin
            chk("lw_wait_req", {31'd0, mem_req}, 32'd1);
            chk("lw_wait_addr", mem_addr, 32'h200);
            chk("lw_wait_stall", {31'd0, ready_in}, 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        chk("lw_req4", {31'd0, mem_req}, 32'd1);
        tick();
        mem_rdata = 32'h12345678;
        chk("lw_c5_wbv", {31'd0, wb_valid}, 32'd0);
        tick();
        chk("lw_c6_wbv", {31'd0, wb_valid}, 32'd1);
        chk("lw_data", wb_data, 32'h12345678);
        chk("lw_rd", {27'd0, wb_rd}, 32'd9);

        issue(1'b1, 1'b0, 3'b010, 32'h202, 32'd0, 5'd4);
        chk("lw_mis_req", {31'd0, mem_req}, 32'd0);
        chk("lw_mis_flag", {31'd0, misaligned}, 32'd1);
        chk("lw_mis_wbv", {31'd0, wb_valid}, 32'd1);
        chk("lw_mis_wbwe", {31'd0, wb_we}, 32'd0);
        chk("lw_mis_ready", {31'd0, ready_in}, 32'd1);
        issue(1'b0, 1'b1, 3'b001, 32'h101, 32'hFFFF, 5'd0);
        chk("sh_mis_req", {31'd0, mem_req}, 32'd0);
        chk("sh_mis_flag", {31'd0, misaligned}, 32'd1);
        chk("sh_mis_wbwe", {31'd0, wb_we}, 32'd0);
        issue(1'b1, 1'b0, 3'b111, 32'h300, 32'd0, 5'd4);
        chk("bad_f3_flag", {31'd0, misaligned}, 32'd1);
        chk("bad_f3_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("mis_pulse", {31'd0, misaligned}, 32'd0);

        mem_ready = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 5'd6);
        chk("rmid_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; mem_ready = 1'b1;
        chk("rmid_req_drop", {31'd0, mem_req}, 32'd0);
        chk("rmid_wbv", {31'd0, wb_valid}, 32'd0);
        chk("rmid_ready", {31'd0, ready_in}, 32'd1);
        tick();
        chk("rmid_wbv2", {31'd0, wb_valid}, 32'd0);
        tick();
        chk("rmid_wbv3", {31'd0, wb_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
